// File: rtl/multicycle_main_control_pkg.sv
// Shared encodings for the multicycle main control FSM: opcodes, ALU op codes,
// state encoding and datapath mux select codes.
package multicycle_main_control_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b000001;
   localparam logic [5:0] OP_SLTI  = 6'b000010;
   localparam logic [5:0] OP_LW    = 6'b000011;
   localparam logic [5:0] OP_SW    = 6'b000100;
   localparam logic [5:0] OP_BEQ   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000110;

   localparam logic [2:0] ALUOP_RTYPE = 3'b000;
   localparam logic [2:0] ALUOP_BEQ   = 3'b001;
   localparam logic [2:0] ALUOP_SLTI  = 3'b010;
   localparam logic [2:0] ALUOP_ADD   = 3'b011;

   localparam logic [1:0] SRCB_RT      = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef enum logic [3:0] {
      S_RST, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR, S_MEM_RD,
      S_MEM_WB, S_MEM_WR, S_R_WB, S_I_WB, S_BRANCH, S_JUMP, S_ERROR
   } state_t;

   // States that hold a memory request open until mem_ready.
   function automatic logic is_mem_wait(input state_t s);
      return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
   endfunction

endpackage

// File: rtl/multicycle_main_control_mem_wait_timer.sv
// Counts consecutive stalled cycles in a memory-wait state; flags a timeout on the
// MEM_TIMEOUT-th stalled cycle unless mem_ready arrives in that cycle.
module multicycle_main_control_mem_wait_timer #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic waiting,
   input  logic mem_ready,
   output logic timeout
);

   logic [7:0] cnt;

   assign timeout = waiting && !mem_ready && (cnt == 8'(MEM_TIMEOUT - 1));

   // Leaving a wait state only happens on mem_ready or timeout, so both clear cnt.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= 8'd0;
      else if (waiting && !mem_ready && !timeout)
         cnt <= cnt + 8'd1;
      else
         cnt <= 8'd0;
   end

endmodule

// File: rtl/multicycle_main_control.sv
// Multicycle main control FSM: sequences each instruction from its opcode and drives
// datapath strobes, mux selects and alu_op; stalls on mem_ready with a bus timeout.
module multicycle_main_control
   import multicycle_main_control_pkg::*;
#(
   parameter int OPCODE_W    = 6,
   parameter int ALUOP_W     = 3,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                mem_ready,
   output logic                pc_write,
   output logic                pc_write_cond,
   output logic                ir_write,
   output logic                iord,
   output logic                mem_read,
   output logic                mem_write,
   output logic                mem_to_reg,
   output logic                reg_dst,
   output logic                reg_write,
   output logic                alu_src_a,
   output logic [1:0]          alu_src_b,
   output logic [1:0]          pc_source,
   output logic [ALUOP_W-1:0]  alu_op,
   output logic                illegal_op,
   output logic                bus_error
);

   state_t              state, next_state;
   logic [OPCODE_W-1:0] op_q;
   logic                timeout;

   multicycle_main_control_mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
      .clk       (clk),
      .rst       (rst),
      .waiting   (is_mem_wait(state)),
      .mem_ready (mem_ready),
      .timeout   (timeout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= S_RST;
      else
         state <= next_state;
   end

   // Opcode is only trusted in DECODE; later states use the captured copy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q       <= '0;
         illegal_op <= 1'b0;
         bus_error  <= 1'b0;
      end else begin
         if (state == S_DECODE)
            op_q <= opcode;
         if (state == S_DECODE && next_state == S_ERROR)
            illegal_op <= 1'b1;
         if (timeout)
            bus_error <= 1'b1;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         S_RST:    next_state = S_FETCH;
         S_FETCH:  next_state = mem_ready ? S_DECODE : (timeout ? S_ERROR : S_FETCH);
         S_DECODE: begin
            case (opcode)
               OPCODE_W'(OP_RTYPE): next_state = S_EXEC_R;
               OPCODE_W'(OP_ADDI),
               OPCODE_W'(OP_SLTI):  next_state = S_EXEC_I;
               OPCODE_W'(OP_LW),
               OPCODE_W'(OP_SW):    next_state = S_MEM_ADDR;
               OPCODE_W'(OP_BEQ):   next_state = S_BRANCH;
               OPCODE_W'(OP_J):     next_state = S_JUMP;
               default:             next_state = S_ERROR;
            endcase
         end
         S_EXEC_R:   next_state = S_R_WB;
         S_EXEC_I:   next_state = S_I_WB;
         S_MEM_ADDR: next_state = (op_q == OPCODE_W'(OP_SW)) ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD:   next_state = mem_ready ? S_MEM_WB : (timeout ? S_ERROR : S_MEM_RD);
         S_MEM_WR:   next_state = mem_ready ? S_FETCH : (timeout ? S_ERROR : S_MEM_WR);
         S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: next_state = S_FETCH;
         S_ERROR:    next_state = S_ERROR;
         default:    next_state = S_ERROR;
      endcase
   end

   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ir_write      = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_RT;
      pc_source     = PCSRC_ALU;
      alu_op        = ALUOP_W'(ALUOP_RTYPE);
      case (state)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = SRCB_FOUR;
            alu_op    = ALUOP_W'(ALUOP_ADD);
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         S_DECODE: begin
            alu_src_b = SRCB_IMM_SH2;
            alu_op    = ALUOP_W'(ALUOP_ADD);
         end
         S_EXEC_R: alu_src_a = 1'b1;
         S_R_WB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         S_EXEC_I: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            alu_op    = (op_q == OPCODE_W'(OP_SLTI)) ? ALUOP_W'(ALUOP_SLTI) : ALUOP_W'(ALUOP_ADD);
         end
         S_I_WB:   reg_write = 1'b1;
         S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            alu_op    = ALUOP_W'(ALUOP_ADD);
         end
         S_MEM_RD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         S_MEM_WR: begin
            mem_write = 1'b1;
            iord      = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = ALUOP_W'(ALUOP_BEQ);
            pc_write_cond = 1'b1;
            pc_source     = PCSRC_ALUOUT;
         end
         S_JUMP: begin
            pc_write  = 1'b1;
            pc_source = PCSRC_JUMP;
         end
         default: ;
      endcase
   end

endmodule
